// File: rtl/wb_commit_queue.sv
// Writeback commit queue: a small circular FIFO of register writes that drains into the
// register file, with two combinational forwarding ports over all queued entries.
module wb_commit_queue #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_we,
  input  logic [AW-1:0]              in_waddr,
  input  logic [XLEN-1:0]            in_wdata,
  output logic                       wb_we,
  output logic [AW-1:0]              wb_waddr,
  output logic [XLEN-1:0]            wb_wdata,
  input  logic                       wb_ready,
  input  logic [AW-1:0]              fwd0_addr,
  input  logic [AW-1:0]              fwd1_addr,
  output logic                       fwd0_hit,
  output logic                       fwd1_hit,
  output logic [XLEN-1:0]            fwd0_data,
  output logic [XLEN-1:0]            fwd1_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]   addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   occ;

  logic pop;
  logic push;

  assign count    = occ;
  assign wb_we    = (occ != '0);
  assign wb_waddr = wb_we ? addr_mem[rd_ptr] : '0;
  assign wb_wdata = wb_we ? data_mem[rd_ptr] : '0;

  assign pop      = wb_we && wb_ready && rdy && !flush;
  assign in_ready = rdy && !rst && !flush && ((occ < FULL) || (occ == FULL && pop));
  // Accepted offers that do not write a real register are swallowed as bubbles.
  assign push     = in_valid && in_ready && in_we && (in_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (rdy) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end
  end

  // Storage carries no reset; only entries covered by the occupancy are ever exposed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_waddr;
      data_mem[wr_ptr] <= in_wdata;
    end
  end

  logic [AW-1:0]   fwd_addr [2];
  logic            fwd_hit  [2];
  logic [XLEN-1:0] fwd_data [2];

  assign fwd_addr[0] = fwd0_addr;
  assign fwd_addr[1] = fwd1_addr;
  assign fwd0_hit    = fwd_hit[0];
  assign fwd1_hit    = fwd_hit[1];
  assign fwd0_data   = fwd_data[0];
  assign fwd1_data   = fwd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic [PW-1:0] idx;
    // Walk oldest to youngest so the last valid match wins.
    always_comb begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      idx         = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < occ) && (fwd_addr[p] != '0) && (addr_mem[idx] == fwd_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = data_mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: a queue model predicts every output each cycle,
// plus directed scenarios for latency, full push/pop, forwarding, bubbles, flush, stall, reset.
module tb_wb_commit_queue;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            rdy;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_we;
  logic [AW-1:0]   in_waddr;
  logic [XLEN-1:0] in_wdata;
  logic            wb_we;
  logic [AW-1:0]   wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_ready;
  logic [AW-1:0]   fwd0_addr;
  logic [AW-1:0]   fwd1_addr;
  logic            fwd0_hit;
  logic            fwd1_hit;
  logic [XLEN-1:0] fwd0_data;
  logic [XLEN-1:0] fwd1_data;
  logic [$clog2(DEPTH):0] count;

  wb_commit_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_waddr(in_waddr), .in_wdata(in_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_ready(wb_ready),
    .fwd0_addr(fwd0_addr), .fwd1_addr(fwd1_addr),
    .fwd0_hit(fwd0_hit), .fwd1_hit(fwd1_hit),
    .fwd0_data(fwd0_data), .fwd1_data(fwd1_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t          sb[$];
  logic [AW-1:0] pop_log[$];
  bit            live = 1'b0;

  function automatic void fwd_model(input logic [AW-1:0] fa, output logic h,
                                    output logic [XLEN-1:0] d);
    h = 1'b0;
    d = '0;
    if (fa != '0)
      foreach (sb[i])
        if (sb[i].a == fa) begin
          h = 1'b1;
          d = sb[i].d;
        end
  endfunction

  // Inputs change just after posedge, so the falling edge sees a stable cycle.
  always @(negedge clk) begin
    logic            exp_pop;
    logic            exp_rdy;
    logic            h;
    logic [XLEN-1:0] d;
    if (live) begin
      exp_pop = (sb.size() != 0) && wb_ready && rdy && !flush;
      exp_rdy = rdy && !rst && !flush &&
                ((sb.size() < DEPTH) || (sb.size() == DEPTH && exp_pop));
      check("count", 64'(count), 64'(sb.size()));
      check("wb_we", 64'(wb_we), 64'(sb.size() != 0));
      check("wb_waddr", 64'(wb_waddr), (sb.size() != 0) ? 64'(sb[0].a) : 64'd0);
      check("wb_wdata", 64'(wb_wdata), (sb.size() != 0) ? 64'(sb[0].d) : 64'd0);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      fwd_model(fwd0_addr, h, d);
      check("fwd0_hit", 64'(fwd0_hit), 64'(h));
      check("fwd0_data", 64'(fwd0_data), 64'(d));
      fwd_model(fwd1_addr, h, d);
      check("fwd1_hit", 64'(fwd1_hit), 64'(h));
      check("fwd1_data", 64'(fwd1_data), 64'(d));
      if (wb_we && wb_ready && rdy && !flush && !rst) pop_log.push_back(wb_waddr);
      if (rst || (rdy && flush)) begin
        sb.delete();
      end else begin
        if (exp_pop) void'(sb.pop_front());
        if (in_valid && exp_rdy && in_we && in_waddr != '0) sb.push_back('{in_waddr, in_wdata});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_we    = 1'b0;
    in_waddr = '0;
    in_wdata = '0;
    flush    = 1'b0;
  endtask

  task automatic offer(input logic we, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    in_valid = 1'b1;
    in_we    = we;
    in_waddr = a;
    in_wdata = d;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; wb_ready = 1'b0;
    fwd0_addr = '0; fwd1_addr = '0;
    idle();
    tick();
    live = 1'b1;
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_wb_we", 64'(wb_we), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // First entry becomes visible the cycle after its edge.
    offer(1'b1, 5'd5, 32'h11);
    #1;
    check("no_bypass_wb_we", 64'(wb_we), 64'd0);
    tick();
    idle();
    check("lat_wb_we", 64'(wb_we), 64'd1);
    check("lat_waddr", 64'(wb_waddr), 64'd5);
    check("lat_wdata", 64'(wb_wdata), 64'h11);
    check("lat_count", 64'(count), 64'd1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // Fill, then push into a full queue while popping.
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, AW'(i), 32'h100 + i);
      tick();
    end
    idle();
    #1;
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    pop_log.delete();
    wb_ready = 1'b1;
    offer(1'b1, 5'd6, 32'h600);
    #1;
    check("full_pop_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    check("full_pop_count", 64'(count), 64'd4);
    repeat (5) tick();
    check("pop_order_len", 64'(pop_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] want;
      want = (i == 4) ? AW'(6) : AW'(i + 1);
      check("pop_order", 64'(pop_log[i]), 64'(want));
    end

    // Youngest match wins; address zero never hits.
    wb_ready = 1'b0;
    offer(1'b1, 5'd3, 32'hA); tick();
    offer(1'b1, 5'd3, 32'hB); tick();
    idle();
    fwd0_addr = 5'd3; fwd1_addr = 5'd0;
    #1;
    check("fwd_young_hit", 64'(fwd0_hit), 64'd1);
    check("fwd_young_data", 64'(fwd0_data), 64'hB);
    check("fwd_zero_hit", 64'(fwd1_hit), 64'd0);
    check("fwd_zero_data", 64'(fwd1_data), 64'd0);
    wb_ready = 1'b1;
    #1;
    check("fwd_head_popping", 64'(fwd0_hit), 64'd1);
    repeat (3) tick();

    // Bubbles are accepted but never enqueued.
    wb_ready = 1'b0;
    offer(1'b0, 5'd9, 32'h9);
    #1;
    check("bubble_we0_ready", 64'(in_ready), 64'd1);
    tick();
    offer(1'b1, 5'd0, 32'h7);
    #1;
    check("bubble_a0_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    check("bubble_count", 64'(count), 64'd0);
    check("bubble_wb_we", 64'(wb_we), 64'd0);

    // Flush wins over a same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, AW'(20 + i), 32'h2000 + i);
      tick();
    end
    idle();
    pop_log.delete();
    flush = 1'b1; wb_ready = 1'b1;
    offer(1'b1, 5'd8, 32'h8);
    tick();
    idle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_wb_we", 64'(wb_we), 64'd0);
    check("flush_writes", 64'(pop_log.size()), 64'd0);

    // Stall holds everything, then draining resumes in order.
    wb_ready = 1'b0;
    offer(1'b1, 5'd10, 32'hA0); tick();
    offer(1'b1, 5'd11, 32'hB0); tick();
    idle();
    pop_log.delete();
    rdy = 1'b0; wb_ready = 1'b1;
    offer(1'b1, 5'd12, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_count", 64'(count), 64'd2);
      check("stall_head", 64'(wb_waddr), 64'd10);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    idle();
    rdy = 1'b1;
    repeat (3) tick();
    check("stall_pop_len", 64'(pop_log.size()), 64'd2);
    check("stall_pop0", 64'(pop_log[0]), 64'd10);
    check("stall_pop1", 64'(pop_log[1]), 64'd11);

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      rdy       = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = $urandom_range(0, 1);
      in_we     = ($urandom_range(0, 3) != 0);
      in_waddr  = AW'($urandom_range(0, 7));
      in_wdata  = $urandom;
      wb_ready  = ($urandom_range(0, 2) != 0);
      fwd0_addr = AW'($urandom_range(0, 7));
      fwd1_addr = AW'($urandom_range(0, 7));
      tick();
    end

    // Reset in the middle of a partly full queue.
    idle();
    rdy = 1'b1; wb_ready = 1'b0;
    repeat (2) tick();
    offer(1'b1, 5'd14, 32'hE0); tick();
    offer(1'b1, 5'd15, 32'hF0); tick();
    pop_log.delete();
    rst = 1'b1; wb_ready = 1'b1;
    offer(1'b1, 5'd16, 32'h1);
    tick();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_wb_we", 64'(wb_we), 64'd0);
    rst = 1'b0;
    idle();
    repeat (2) tick();
    check("mid_rst_writes", 64'(pop_log.size()), 64'd0);

    live = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
